multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Main control FSM for the multicycle variant of the RV32I core. It sequences the shared ALU, the unified instruction/data memory port, the instruction register and the register file across 3–5 cycles per instruction. It drives `ALUOp` into the existing ALU decoder; that decoder still turns `ALUOp`/`funct3`/`funct7b5` into `ALUControl`. A memory ready handshake stretches fetch, load and store cycles.

## Interface
- No parameters.
- `clk` input 1 — rising-edge clock.
- `rst_n` input 1 — asynchronous, active-low reset.
- `op` input 7 — instruction opcode bits [6:0] from the instruction register.
- `funct3` input 3 — instruction bits [14:12]; bit 0 selects beq (0) or bne (1).
- `zero` input 1 — ALU zero flag.
- `mem_ready` input 1 — memory completes the current access this cycle.
- `PCWrite` output 1 — PC register enable.
- `AdrSrc` output 1 — memory address select: 0 = PC, 1 = ALUOut.
- `MemWrite` output 1 — memory write strobe.
- `IRWrite` output 1 — instruction register and OldPC enable.
- `RegWrite` output 1 — register file write enable.
- `ResultSrc` output 2 — result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` output 2 — ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- `ALUSrcB` output 2 — ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
- `ALUOp` output 2 — to the ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded.
- `ImmSrc` output 2 — immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `instr_done` output 1 — one-cycle pulse when an instruction retires.
- `illegal` output 1 — one-cycle pulse in DECODE when the opcode is unsupported.
- `state` output 4 — current state, for debug.

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BRANCH=10. Encodings 11–15 are unused; from any of them the next state is FETCH and all outputs are 0.
- Transitions:
  - FETCH → DECODE when `mem_ready`=1; otherwise stay in FETCH.
  - DECODE → by `op`:
    - 0000011 (lw) → MEMADR
    - 0100011 (sw) → MEMADR
    - 0110011 (R-type) → EXECUTER
    - 0010011 (I-ALU) → EXECUTEI
    - 1101111 (jal) → JAL
    - 1100011 (branch) → BRANCH
    - any other opcode → FETCH, with `illegal`=1
  - MEMADR → MEMREAD if `op`=lw, MEMWRITE if `op`=sw.
  - MEMREAD → MEMWB when `mem_ready`=1; otherwise hold.
  - MEMWRITE → FETCH when `mem_ready`=1; otherwise hold.
  - MEMWB → FETCH.
  - EXECUTER → ALUWB. EXECUTEI → ALUWB. JAL → ALUWB.
  - ALUWB → FETCH. BRANCH → FETCH.
- Outputs are decoded from state; every output not listed for a state is 0.
  - FETCH: `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=10. `IRWrite`=`mem_ready`, `PCWrite`=`mem_ready`.
  - DECODE: `ALUSrcA`=01, `ALUSrcB`=01, `ALUOp`=00 (computes the branch target).
  - MEMADR: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=00.
  - MEMREAD: `AdrSrc`=1, `ResultSrc`=00.
  - MEMWB: `ResultSrc`=01, `RegWrite`=1.
  - MEMWRITE: `AdrSrc`=1, `MemWrite`=1. The strobe is held until the `mem_ready` cycle.
  - EXECUTER: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=10.
  - EXECUTEI: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=10.
  - ALUWB: `ResultSrc`=00, `RegWrite`=1.
  - JAL: `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=00, `PCWrite`=1.
  - BRANCH: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=01, `ResultSrc`=00. `PCWrite` = `zero` XOR `funct3[0]`.
- `ImmSrc` is combinational from `op` in every state:
  - lw / I-ALU → 00
  - sw → 01
  - branch → 10
  - jal → 11
  - any other opcode → 00
- `instr_done`=1 in:
  - MEMWB
  - ALUWB
  - BRANCH
  - MEMWRITE when `mem_ready`=1

## Timing
- Reset: `rst_n` low forces `state`=FETCH immediately (asynchronous). While reset is asserted:
  - registered and state-decoded outputs are at their FETCH values, with `IRWrite`=0 and `PCWrite`=0 regardless of `mem_ready`;
  - `instr_done`=0 and `illegal`=0;
  - `ImmSrc` still follows `op`.
- Reset release is synchronous to `clk`; the first fetch can complete on the first rising edge after release.
- Reset asserted mid-instruction abandons the instruction. No write strobe may remain asserted.
- Latency with `mem_ready` held high:
  - branch: 3 cycles
  - R-type, I-ALU, jal, sw: 4 cycles
  - lw: 5 cycles
  - Each low `mem_ready` cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- `mem_ready` is sampled only in FETCH, MEMREAD and MEMWRITE; it is ignored in all other states.
- Register writes (`PCWrite`, `IRWrite`, `RegWrite`, `MemWrite`) take effect at the rising edge that ends the state asserting them.
- A branch is evaluated with the `zero` value present during the BRANCH cycle.

## Test plan
- Reset, then R-type add (`op`=0110011), `mem_ready`=1 → states 0,1,6,7,0. `ALUOp`=10 in EXECUTER. `RegWrite`=1 only in ALUWB. `instr_done` pulses once.
- lw with `mem_ready` low for 2 cycles in FETCH and 1 cycle in MEMREAD → states 0,0,0,1,2,3,3,4,0. `IRWrite` high only in the third FETCH cycle. `ResultSrc`=01 in MEMWB.
- sw with `mem_ready`=0 for 3 cycles in MEMWRITE → `MemWrite` high for 4 consecutive cycles, `ImmSrc`=01, `instr_done` only on the final cycle.
- beq (`funct3`=000) with `zero`=1, then `zero`=0; bne (`funct3`=001) with `zero`=0 → `PCWrite` in BRANCH is 1, 0, 1 respectively. `ALUOp`=01 in BRANCH.
- `op`=1111111 → `illegal` pulses in DECODE, next state FETCH, no `RegWrite`, `MemWrite` or `instr_done`.
- `rst_n` pulsed low asynchronously during MEMWRITE → `state`=0 and `MemWrite`=0 before the next clock edge. A normal fetch follows after release.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences ALU, unified memory
// port, instruction register and register file over 3-5 cycles per instruction.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10
    } state_t;

    state_t state_q, state_d;

    assign state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next state and state-decoded controls. The fetch enables are gated by
    // rst_n so no write fires while the core is held in reset.
    always_comb begin
        state_d    = S_FETCH;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                state_d   = mem_ready ? S_DECODE : S_FETCH;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready & rst_n;
                PCWrite   = mem_ready & rst_n;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_IALU:      state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BRANCH:    state_d = S_BRANCH;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                state_d    = S_FETCH;
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                state_d    = mem_ready ? S_FETCH : S_MEMWRITE;
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTER: begin
                state_d = S_ALUWB;
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECUTEI: begin
                state_d = S_ALUWB;
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                state_d    = S_FETCH;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                state_d = S_ALUWB;
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_BRANCH: begin
                state_d    = S_FETCH;
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b01;
                PCWrite    = zero ^ funct3[0];
                instr_done = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:     ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// cycle by cycle and compares state and controls against hand-derived tables.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic       instr_done, illegal;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .instr_done(instr_done),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic step(input logic mr, input logic z);
        @(negedge clk);
        mem_ready = mr;
        zero      = z;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op = 7'b0100011; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b1;
        #3;
        checks += 7;
        if (state !== 4'd0)      begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        if (IRWrite !== 1'b0)    begin failures++; $display("FAIL reset_irwrite got=%b exp=0", IRWrite); end
        if (PCWrite !== 1'b0)    begin failures++; $display("FAIL reset_pcwrite got=%b exp=0", PCWrite); end
        if (ALUSrcB !== 2'b10)   begin failures++; $display("FAIL reset_alusrcb got=%b exp=10", ALUSrcB); end
        if (ResultSrc !== 2'b10) begin failures++; $display("FAIL reset_resultsrc got=%b exp=10", ResultSrc); end
        if (ImmSrc !== 2'b01)    begin failures++; $display("FAIL reset_immsrc_sw got=%b exp=01", ImmSrc); end
        if (instr_done !== 1'b0 || illegal !== 1'b0) begin
            failures++; $display("FAIL reset_pulses got=%b%b exp=00", instr_done, illegal);
        end
        op = 7'b1100011;
        #1;
        checks++;
        if (ImmSrc !== 2'b10) begin failures++; $display("FAIL reset_immsrc_br got=%b exp=10", ImmSrc); end
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rtype();
        int   exp_st[5]  = '{0, 1, 6, 7, 0};
        int   exp_op[5]  = '{0, 0, 2, 0, 0};
        logic exp_rw[5]  = '{0, 0, 0, 1, 0};
        logic exp_dn[5]  = '{0, 0, 0, 1, 0};
        op = 7'b0110011;
        for (int i = 0; i < 5; i++) begin
            step((i == 4) ? 1'b0 : 1'b1, 1'b0);
            checks += 4;
            if (state !== 4'(exp_st[i])) begin failures++; $display("FAIL rtype_state c%0d got=%0d exp=%0d", i, state, exp_st[i]); end
            if (ALUOp !== 2'(exp_op[i])) begin failures++; $display("FAIL rtype_aluop c%0d got=%0d exp=%0d", i, ALUOp, exp_op[i]); end
            if (RegWrite !== exp_rw[i])  begin failures++; $display("FAIL rtype_regwrite c%0d got=%b exp=%b", i, RegWrite, exp_rw[i]); end
            if (instr_done !== exp_dn[i]) begin failures++; $display("FAIL rtype_done c%0d got=%b exp=%b", i, instr_done, exp_dn[i]); end
        end
    endtask

    task automatic test_lw_stall();
        logic mr[9]     = '{0, 0, 1, 1, 1, 0, 1, 1, 0};
        int   exp_st[9] = '{0, 0, 0, 1, 2, 3, 3, 4, 0};
        logic exp_ir[9] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
        int   exp_rs[9] = '{2, 2, 2, 0, 0, 0, 0, 1, 2};
        op = 7'b0000011;
        for (int i = 0; i < 9; i++) begin
            step(mr[i], 1'b0);
            checks += 3;
            if (state !== 4'(exp_st[i]))     begin failures++; $display("FAIL lw_state c%0d got=%0d exp=%0d", i, state, exp_st[i]); end
            if (IRWrite !== exp_ir[i])       begin failures++; $display("FAIL lw_irwrite c%0d got=%b exp=%b", i, IRWrite, exp_ir[i]); end
            if (ResultSrc !== 2'(exp_rs[i])) begin failures++; $display("FAIL lw_resultsrc c%0d got=%0d exp=%0d", i, ResultSrc, exp_rs[i]); end
        end
    endtask

    task automatic test_sw_stall();
        logic mr[8]     = '{1, 1, 1, 0, 0, 0, 1, 0};
        int   exp_st[8] = '{0, 1, 2, 5, 5, 5, 5, 0};
        logic exp_mw[8] = '{0, 0, 0, 1, 1, 1, 1, 0};
        logic exp_dn[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
        op = 7'b0100011;
        for (int i = 0; i < 8; i++) begin
            step(mr[i], 1'b0);
            checks += 4;
            if (state !== 4'(exp_st[i]))  begin failures++; $display("FAIL sw_state c%0d got=%0d exp=%0d", i, state, exp_st[i]); end
            if (MemWrite !== exp_mw[i])   begin failures++; $display("FAIL sw_memwrite c%0d got=%b exp=%b", i, MemWrite, exp_mw[i]); end
            if (instr_done !== exp_dn[i]) begin failures++; $display("FAIL sw_done c%0d got=%b exp=%b", i, instr_done, exp_dn[i]); end
            if (ImmSrc !== 2'b01)         begin failures++; $display("FAIL sw_immsrc c%0d got=%b exp=01", i, ImmSrc); end
        end
    endtask

    task automatic test_branch(input logic [2:0] f3, input logic z, input logic exp_pc);
        op = 7'b1100011; funct3 = f3;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        checks += 2;
        if (state !== 4'd1)   begin failures++; $display("FAIL br_decode_state got=%0d exp=1", state); end
        if (PCWrite !== 1'b0) begin failures++; $display("FAIL br_decode_pcwrite got=%b exp=0", PCWrite); end
        step(1'b1, z);
        checks += 5;
        if (state !== 4'd10)    begin failures++; $display("FAIL br_state got=%0d exp=10", state); end
        if (PCWrite !== exp_pc) begin failures++; $display("FAIL br_pcwrite f3=%0d z=%b got=%b exp=%b", f3, z, PCWrite, exp_pc); end
        if (ALUOp !== 2'b01)    begin failures++; $display("FAIL br_aluop got=%b exp=01", ALUOp); end
        if (instr_done !== 1'b1) begin failures++; $display("FAIL br_done got=%b exp=1", instr_done); end
        if (ImmSrc !== 2'b10)   begin failures++; $display("FAIL br_immsrc got=%b exp=10", ImmSrc); end
        step(1'b0, 1'b0);
        checks++;
        if (state !== 4'd0) begin failures++; $display("FAIL br_return got=%0d exp=0", state); end
    endtask

    task automatic test_jal();
        int   exp_st[5] = '{0, 1, 9, 7, 0};
        logic exp_pc[5] = '{1, 0, 1, 0, 0};
        logic exp_rw[5] = '{0, 0, 0, 1, 0};
        op = 7'b1101111;
        for (int i = 0; i < 5; i++) begin
            step((i == 4) ? 1'b0 : 1'b1, 1'b0);
            checks += 4;
            if (state !== 4'(exp_st[i])) begin failures++; $display("FAIL jal_state c%0d got=%0d exp=%0d", i, state, exp_st[i]); end
            if (PCWrite !== exp_pc[i])   begin failures++; $display("FAIL jal_pcwrite c%0d got=%b exp=%b", i, PCWrite, exp_pc[i]); end
            if (RegWrite !== exp_rw[i])  begin failures++; $display("FAIL jal_regwrite c%0d got=%b exp=%b", i, RegWrite, exp_rw[i]); end
            if (ImmSrc !== 2'b11)        begin failures++; $display("FAIL jal_immsrc c%0d got=%b exp=11", i, ImmSrc); end
        end
    endtask

    task automatic test_illegal();
        op = 7'b1111111;
        step(1'b1, 1'b0);
        checks++;
        if (illegal !== 1'b0) begin failures++; $display("FAIL ill_fetch got=%b exp=0", illegal); end
        step(1'b1, 1'b0);
        checks += 4;
        if (state !== 4'd1)   begin failures++; $display("FAIL ill_state got=%0d exp=1", state); end
        if (illegal !== 1'b1) begin failures++; $display("FAIL ill_pulse got=%b exp=1", illegal); end
        if (ImmSrc !== 2'b00) begin failures++; $display("FAIL ill_immsrc got=%b exp=00", ImmSrc); end
        if (RegWrite !== 1'b0 || MemWrite !== 1'b0 || instr_done !== 1'b0) begin
            failures++; $display("FAIL ill_writes got=%b%b%b exp=000", RegWrite, MemWrite, instr_done);
        end
        step(1'b0, 1'b0);
        checks += 2;
        if (state !== 4'd0)   begin failures++; $display("FAIL ill_next got=%0d exp=0", state); end
        if (illegal !== 1'b0) begin failures++; $display("FAIL ill_clear got=%b exp=0", illegal); end
    endtask

    task automatic test_reset_midwrite();
        op = 7'b0100011;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        checks += 2;
        if (state !== 4'd5)    begin failures++; $display("FAIL rstw_pre_state got=%0d exp=5", state); end
        if (MemWrite !== 1'b1) begin failures++; $display("FAIL rstw_pre_memwrite got=%b exp=1", MemWrite); end
        #1;
        rst_n = 1'b0; mem_ready = 1'b1;
        #1;
        checks += 4;
        if (state !== 4'd0)    begin failures++; $display("FAIL rstw_state got=%0d exp=0", state); end
        if (MemWrite !== 1'b0) begin failures++; $display("FAIL rstw_memwrite got=%b exp=0", MemWrite); end
        if (IRWrite !== 1'b0)  begin failures++; $display("FAIL rstw_irwrite got=%b exp=0", IRWrite); end
        if (PCWrite !== 1'b0)  begin failures++; $display("FAIL rstw_pcwrite got=%b exp=0", PCWrite); end
        @(posedge clk);
        #1;
        checks++;
        if (state !== 4'd0) begin failures++; $display("FAIL rstw_hold got=%0d exp=0", state); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (IRWrite !== 1'b1) begin failures++; $display("FAIL rstw_fetch_ir got=%b exp=1", IRWrite); end
        @(posedge clk);
        #1;
        checks++;
        if (state !== 4'd1) begin failures++; $display("FAIL rstw_decode got=%0d exp=1", state); end
        op = 7'b1111111;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (state !== 4'd0) begin failures++; $display("FAIL rstw_return got=%0d exp=0", state); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_sw_stall();
        test_branch(3'b000, 1'b1, 1'b1);
        test_branch(3'b000, 1'b0, 1'b0);
        test_branch(3'b001, 1'b0, 1'b1);
        test_jal();
        test_illegal();
        test_reset_midwrite();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout reached without completing");
        $fatal(1);
    end

endmodule
